alu_op_sequencer: RTL

- Controller that fronts the 32-bit ripple ALU built from 1-bit slices.
- Accepts one operation at a time over a start/ready handshake and decodes the 6-bit funct into ALU controls (signal, binvert, cin).
- Single-pass ops (ADD/SUB/AND/OR/SLT) use one ALU pass; SLL/SRL run iteratively, one bit per cycle.
- MULTU runs as 32 shift-add passes through the ALU adder into a 64-bit HI/LO result.

---
 rtl/alu_op_sequencer_if.sv | 45 ++++
 rtl/alu_op_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request/response and ALU-drive bundle for alu_op_sequencer.
//
// Request side: start/ready handshake, funct, src_a, src_b and shamt.
// Response side: done pulse, result_lo/result_hi, err and ovf.
// ALU side: alu_a, alu_b, alu_binvert, alu_cin and alu_signal go out to the
// ripple ALU. alu_result and alu_cout come back combinationally.
//
// The slave modport is the sequencer's view. The master modport is the
// environment's view, which covers both the requester and the ALU.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             ready;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [4:0]       shamt;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_binvert;
    logic             alu_cin;
    logic [5:0]       alu_signal;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;

    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             err;
    logic             ovf;

    modport master (
        output start, funct, src_a, src_b, shamt, alu_result, alu_cout,
        input  ready, alu_a, alu_b, alu_binvert, alu_cin, alu_signal,
        input  done, result_lo, result_hi, err, ovf
    );

    modport slave (
        input  start, funct, src_a, src_b, shamt, alu_result, alu_cout,
        output ready, alu_a, alu_b, alu_binvert, alu_cin, alu_signal,
        output done, result_lo, result_hi, err, ovf
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: controller in front of a ripple ALU built from 1-bit slices.
//
// The controller accepts one operation on start & ready and decodes funct into
// alu_signal, alu_binvert and alu_cin.
// - ADD, SUB, AND, OR and SLT take one ALU pass (state EXEC).
// - SLL and SRL shift one bit per cycle (state SHIFT).
// - MULTU runs WIDTH shift-add passes through the ALU adder (state MUL) and
//   leaves a 64-bit HI/LO result.
// - An unknown funct takes one EXEC cycle with no ALU drive. It then reports
//   err together with done.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    alu_op_sequencer_if.slave, which carries the handshake, operands,
//          ALU drive and results
//
// Optional feature: define ALU_OP_SEQ_OVF_EN to latch signed overflow for
// ADD/SUB into ovf. When it is undefined, ovf is tied 0.
//
// All outputs are registered. The ALU drive is set on the edge that enters
// EXEC/MUL, so alu_result is valid during that state.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    alu_op_sequencer_if.slave bus
);
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    localparam int unsigned MSB  = WIDTH - 1;
    // The counter must hold both shamt (5 bits) and WIDTH.
    localparam int unsigned CLOG = $clog2(WIDTH + 1);
    localparam int unsigned CW   = (CLOG > 5) ? CLOG : 5;

    typedef enum logic [2:0] {
        st_idle,
        st_exec,
        st_shift,
        st_mul,
        st_done
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [5:0]       op_funct;
    logic [CW-1:0]    cnt;

    logic             op_known;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;

    // A latched funct that is one of the single-pass ALU ops.
    always_comb begin
        op_known = 1'b0;
        unique case (op_funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: op_known = 1'b1;
            default:                          op_known = 1'b0;
        endcase
    end

    // One shift-add step: {HI,LO} <= {cout, sum, LO} >> 1.
    always_comb begin
        mul_hi_nxt = {bus.alu_cout, bus.alu_result[MSB:1]};
        mul_lo_nxt = {bus.alu_result[0], bus.result_lo[MSB:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= st_idle;
            op_a            <= '0;
            op_funct        <= '0;
            cnt             <= '0;
            bus.ready       <= 1'b1;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            bus.result_lo   <= '0;
            bus.result_hi   <= '0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_binvert <= 1'b0;
            bus.alu_cin     <= 1'b0;
            bus.alu_signal  <= '0;
`ifdef ALU_OP_SEQ_OVF_EN
            bus.ovf         <= 1'b0;
`endif
        end else begin
            unique case (state)
                st_idle: begin
                    if (bus.start) begin
                        bus.ready     <= 1'b0;
                        bus.err       <= 1'b0;
`ifdef ALU_OP_SEQ_OVF_EN
                        bus.ovf       <= 1'b0;
`endif
                        bus.result_hi <= '0;
                        op_a          <= bus.src_a;
                        op_funct      <= bus.funct;
                        unique case (bus.funct)
                            F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
                                state           <= st_exec;
                                bus.alu_a       <= bus.src_a;
                                bus.alu_b       <= bus.src_b;
                                bus.alu_signal  <= bus.funct;
                                // Subtract-class ops add ~B + 1.
                                bus.alu_binvert <= (bus.funct == F_SUB) ||
                                                   (bus.funct == F_SLT);
                                bus.alu_cin     <= (bus.funct == F_SUB) ||
                                                   (bus.funct == F_SLT);
                            end
                            F_SLL, F_SRL: begin
                                state         <= st_shift;
                                bus.result_lo <= bus.src_b;
                                cnt           <= CW'(bus.shamt);
                            end
                            F_MULTU: begin
                                state           <= st_mul;
                                bus.result_lo   <= bus.src_b;
                                cnt             <= CW'(WIDTH);
                                bus.alu_a       <= '0;
                                bus.alu_b       <= bus.src_b[0] ? bus.src_a : '0;
                                bus.alu_signal  <= F_ADD;
                                bus.alu_binvert <= 1'b0;
                                bus.alu_cin     <= 1'b0;
                            end
                            default: begin
                                // Unknown funct: no ALU drive, report err in DONE.
                                state <= st_exec;
                            end
                        endcase
                    end
                end

                st_exec: begin
                    if (op_known) begin
                        bus.result_lo <= bus.alu_result;
                    end else begin
                        bus.result_lo <= '0;
                        bus.err       <= 1'b1;
                    end
`ifdef ALU_OP_SEQ_OVF_EN
                    if ((op_funct == F_ADD) || (op_funct == F_SUB)) begin
                        bus.ovf <= (op_a[MSB] == (bus.alu_b[MSB] ^ bus.alu_binvert)) &&
                                   (bus.alu_result[MSB] != op_a[MSB]);
                    end
`endif
                    bus.alu_a       <= '0;
                    bus.alu_b       <= '0;
                    bus.alu_signal  <= '0;
                    bus.alu_binvert <= 1'b0;
                    bus.alu_cin     <= 1'b0;
                    bus.done        <= 1'b1;
                    state           <= st_done;
                end

                st_shift: begin
                    if (cnt != '0) begin
                        if (op_funct == F_SLL) begin
                            bus.result_lo <= {bus.result_lo[MSB-1:0], 1'b0};
                        end else begin
                            bus.result_lo <= {1'b0, bus.result_lo[MSB:1]};
                        end
                        cnt <= cnt - CW'(1);
                    end else begin
                        bus.done <= 1'b1;
                        state    <= st_done;
                    end
                end

                st_mul: begin
                    if (cnt != '0) begin
                        bus.result_hi <= mul_hi_nxt;
                        bus.result_lo <= mul_lo_nxt;
                        cnt           <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            // Last pass: release the ALU for the closing cycle.
                            bus.alu_a      <= '0;
                            bus.alu_b      <= '0;
                            bus.alu_signal <= '0;
                        end else begin
                            // The next LO[0] is the current LO[1].
                            bus.alu_a <= mul_hi_nxt;
                            bus.alu_b <= bus.result_lo[1] ? op_a : '0;
                        end
                    end else begin
                        bus.done <= 1'b1;
                        state    <= st_done;
                    end
                end

                st_done: begin
                    bus.done  <= 1'b0;
                    bus.err   <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= st_idle;
                end

                default: begin
                    state     <= st_idle;
                    bus.ready <= 1'b1;
                    bus.done  <= 1'b0;
                end
            endcase
        end
    end

`ifndef ALU_OP_SEQ_OVF_EN
    assign bus.ovf = 1'b0;
`endif

endmodule
